tt_sweep_collector: RTL and testbench

//  Exhaustive truth-table extractor for one 7-input single-output function block.

---
 rtl/tt_pkg.sv | 27 ++
 rtl/tt_tag_pipe.sv | 37 +++
 rtl/tt_sweep_collector.sv | 112 +++++++++++
 tb/tb_tt_sweep_collector.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_pkg.sv
// Shared types and constants for the truth-table sweep collector.
// The function block under test has NVAR inputs, so its truth table is TT_W bits wide.
package tt_pkg;

    localparam int NVAR = 7;
    localparam int TT_W = 2 ** NVAR;

    typedef logic [TT_W-1:0] tt_t;
    typedef logic [NVAR-1:0] minterm_t;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DRAIN,
        HOLD
    } state_t;

    typedef struct packed {
        logic     valid;
        minterm_t m;
    } tag_t;

    // Reference tables for common blocks: 3-input majority, and a block that passes x6 through.
    localparam tt_t MAJ3_TT = {16{8'hE8}};
    localparam tt_t X6_TT   = {{64{1'b1}}, {64{1'b0}}};

endpackage

// File: rtl/tt_tag_pipe.sv
// Delays the {valid, minterm} tag by LAT cycles so it lines up with the block's output.
// With LAT = 0 the tag passes straight through.
module tt_tag_pipe
    import tt_pkg::*;
#(
    parameter int unsigned LAT = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  tag_t tag_in,
    output tag_t tag_out
);

    if (LAT == 0) begin : g_bypass
        logic unused_ok;
        assign unused_ok = &{1'b0, clk, rst_n, clr};
        assign tag_out   = tag_in;
    end else begin : g_pipe
        tag_t stage [LAT];

        // NOTE: every stage carries a valid flag, so all stages are reset and cleared; a stale valid would corrupt the next table.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < int'(LAT); i++) stage[i] <= '0;
            end else if (clr) begin
                for (int i = 0; i < int'(LAT); i++) stage[i] <= '0;
            end else begin
                stage[0] <= tag_in;
                for (int i = 1; i < int'(LAT); i++) stage[i] <= stage[i-1];
            end
        end

        assign tag_out = stage[LAT-1];
    end

endmodule

// File: rtl/tt_sweep_collector.sv
// Sweeps a 7-input function block through all minterms, captures its truth table,
// on-set count and expected-table match, and hands the result out over valid/ready.
module tt_sweep_collector
    import tt_pkg::*;
#(
    parameter int unsigned LAT = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  tt_t             exp_tt,
    output logic [NVAR-1:0] x,
    input  logic            dut_out,
    output logic            busy,
    output tt_t             tt,
    output logic [7:0]      ones,
    output logic            match,
    output logic            tt_valid,
    input  logic            tt_ready
);

    localparam logic [2:0] LAT_C  = 3'(LAT);
    localparam minterm_t   M_LAST = '1;

    state_t     state;
    state_t     state_nxt;
    minterm_t   m;
    logic [2:0] drain_cnt;
    tt_t        exp_q;
    tag_t       tag_in;
    tag_t       tag_out;

    assign tag_in = '{valid: (state == SWEEP), m: m};
    assign x      = m;

    tt_tag_pipe #(.LAT(LAT)) u_tag_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (abort),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        tt_valid  = (state == HOLD);
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start)               state_nxt = SWEEP;
                SWEEP:   if (m == M_LAST)         state_nxt = DRAIN;
                DRAIN:   if (drain_cnt == LAT_C)  state_nxt = HOLD;
                HOLD:    if (tt_ready)            state_nxt = IDLE;
                default:                          state_nxt = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m         <= '0;
            drain_cnt <= '0;
            exp_q     <= '0;
            tt        <= '0;
            ones      <= '0;
            match     <= 1'b0;
        end else if (abort) begin
            m         <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        m     <= '0;
                        tt    <= '0;
                        ones  <= '0;
                        exp_q <= exp_tt;
                    end
                end
                SWEEP: begin
                    drain_cnt <= '0;
                    if (m != M_LAST) m <= m + minterm_t'(1);
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt + 3'd1;
                    // Last capture landed on the previous edge, so tt is final here.
                    if (drain_cnt == LAT_C) match <= (tt == exp_q);
                end
                HOLD: begin
                    if (tt_ready) m <= '0;
                end
                default: ;
            endcase

            if (tag_out.valid) begin
                tt[tag_out.m] <= dut_out;
                ones          <= ones + 8'(dut_out);
            end
        end
    end

endmodule

// File: tb/tb_tt_sweep_collector.sv
// Scoreboard bench for tt_sweep_collector: a LAT=0 and a LAT=3 instance, directed sweeps,
// stall, abort and mid-sweep reset cases.
module tb_tt_sweep_collector;
    import tt_pkg::*;

    localparam tt_t NET7_TT = 128'hfeeefee8_feeaa880_feeaa880_e8808880;

    typedef struct {
        tt_t        tt;
        logic [7:0] ones;
        logic       match;
        int         lat;
        int         s_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       start, abort, tt_ready, sel;
    logic [1:0] mode;
    tt_t        exp_tt;

    logic [6:0] x0, x3;
    logic       out0, out3, busy0, busy3, v0, v3, m0, m3;
    tt_t        tt0, tt3;
    logic [7:0] ones0, ones3;
    logic       start0, start3;
    logic [2:0] x6_dly;

    assign start0 = start & ~sel;
    assign start3 = start & sel;

    tt_sweep_collector #(.LAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort), .exp_tt(exp_tt),
        .x(x0), .dut_out(out0), .busy(busy0), .tt(tt0), .ones(ones0), .match(m0),
        .tt_valid(v0), .tt_ready(tt_ready)
    );

    tt_sweep_collector #(.LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort), .exp_tt(exp_tt),
        .x(x3), .dut_out(out3), .busy(busy3), .tt(tt3), .ones(ones3), .match(m3),
        .tt_valid(v3), .tt_ready(tt_ready)
    );

    function automatic logic maj(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Hand-built 7-input majority-style network, written per x[6:3] slice.
    function automatic logic net7(input logic [6:0] v);
        logic a, b, c, r;
        a = v[0]; b = v[1]; c = v[2];
        case (v[6:3])
            4'd0, 4'd2, 4'd4, 4'd8:    r = a & b & c;
            4'd1:                      r = a & b;
            4'd3, 4'd12:               r = maj(a, b, c);
            4'd5, 4'd9:                r = a & (b | c);
            4'd6, 4'd10:               r = a | (b & c);
            4'd14:                     r = a | b;
            default:                   r = a | b | c;
        endcase
        return r;
    endfunction

    always_comb begin
        case (mode)
            2'd1:    out0 = maj(x0[0], x0[1], x0[2]);
            2'd2:    out0 = net7(x0);
            default: out0 = 1'b0;
        endcase
    end

    // LAT=3 block: x6 delayed by three registers.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) x6_dly <= '0;
        else        x6_dly <= {x6_dly[1:0], x3[6]};
    end
    assign out3 = x6_dly[2];

    logic       cur_busy, cur_v, cur_m;
    logic [6:0] cur_x;
    tt_t        cur_tt;
    logic [7:0] cur_ones;
    always_comb begin
        cur_busy = sel ? busy3 : busy0;
        cur_v    = sel ? v3    : v0;
        cur_m    = sel ? m3    : m0;
        cur_x    = sel ? x3    : x0;
        cur_tt   = sel ? tt3   : tt0;
        cur_ones = sel ? ones3 : ones0;
    end

    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: checks latency on tt_valid rise, pops and compares on each handshake,
    // and checks outputs stay frozen while stalled.
    initial begin : monitor
        logic       pv = 1'b0;
        logic       pstall = 1'b0;
        tt_t        s_tt;
        logic [7:0] s_ones;
        logic       s_match;
        exp_t       e;
        forever begin
            @(negedge clk); #1;
            if (!rst_n) begin
                pv = 1'b0; pstall = 1'b0;
                continue;
            end
            if (pstall) begin
                check("stall_tt", cur_tt, s_tt);
                check("stall_ones", cur_ones, s_ones);
                check("stall_match", cur_m, s_match);
                check("stall_valid", cur_v, 1);
            end
            if (cur_v && !pv) begin
                if (sb.size() == 0) check("unexpected_result", cur_v, 0);
                else                check("latency", cyc - sb[0].s_cyc, sb[0].lat);
            end
            if (cur_v && tt_ready && sb.size() > 0) begin
                e = sb.pop_front();
                check("tt", cur_tt, e.tt);
                check("ones", cur_ones, e.ones);
                check("match", cur_m, e.match);
            end
            pstall  = cur_v && !tt_ready;
            s_tt    = cur_tt;
            s_ones  = cur_ones;
            s_match = cur_m;
            pv      = cur_v;
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic launch(input logic s, input logic [1:0] md, input tt_t e_in,
                          input tt_t e_tt, input logic [7:0] e_ones, input logic e_match,
                          input bit push);
        @(negedge clk);
        sel = s; mode = md; exp_tt = e_in; start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        exp_tt = '0;
        if (push) sb.push_back('{e_tt, e_ones, e_match, (s ? 132 : 129), cyc});
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (cur_busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({name, "_done"}, cur_busy, 0);
    endtask

    task automatic wait_x(input string name, input logic [6:0] target);
        int n = 0;
        while (cur_x != target && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({name, "_reach"}, cur_x, target);
    endtask

    initial begin : stim
        int n;
        start = 1'b0; abort = 1'b0; tt_ready = 1'b1; exp_tt = '0; sel = 1'b0; mode = 2'd0;
        repeat (3) @(negedge clk);
        check("rst_busy0", busy0, 0);
        check("rst_x0", x0, 0);
        check("rst_valid0", v0, 0);
        check("rst_tt0", tt0, 0);
        check("rst_ones0", ones0, 0);
        check("rst_match0", m0, 0);
        check("rst_busy3", busy3, 0);
        check("rst_valid3", v3, 0);
        rst_n = 1'b1;

        // Constant-0 block, expected table 0.
        launch(1'b0, 2'd0, '0, '0, 8'd0, 1'b1, 1'b1);
        wait_idle("t1");

        // 3-input majority with a wrong expected bit 0.
        launch(1'b0, 2'd1, MAJ3_TT ^ 128'd1, MAJ3_TT, 8'd64, 1'b0, 1'b1);
        wait_idle("t2");

        // 7-input network.
        launch(1'b0, 2'd2, NET7_TT, NET7_TT, 8'd64, 1'b1, 1'b1);
        wait_idle("t3");

        // LAT=3 instance, x6 delayed three cycles.
        launch(1'b1, 2'd0, X6_TT, X6_TT, 8'd64, 1'b1, 1'b1);
        wait_idle("t4");

        // Stall in HOLD, ignored start pulses, single transfer.
        tt_ready = 1'b0;
        launch(1'b0, 2'd1, MAJ3_TT, MAJ3_TT, 8'd64, 1'b1, 1'b1);
        repeat (20) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!cur_v && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("t5_valid", cur_v, 1);
        check("t5_x_hold", cur_x, 127);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        tt_ready = 1'b1; start = 1'b1;
        @(negedge clk);
        tt_ready = 1'b0; start = 1'b0;
        check("t5_busy_after", cur_busy, 0);
        check("t5_x_idle", cur_x, 0);
        repeat (5) @(negedge clk);
        check("t5_no_restart", cur_busy, 0);
        check("t5_no_second", cur_v, 0);
        tt_ready = 1'b1;

        // Abort at m=50.
        launch(1'b0, 2'd1, MAJ3_TT, '0, 8'd0, 1'b0, 1'b0);
        wait_x("t6a", 7'd50);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t6a_busy", cur_busy, 0);
        check("t6a_x", cur_x, 0);
        check("t6a_valid", cur_v, 0);
        repeat (150) @(negedge clk);
        check("t6a_still_idle", cur_v, 0);
        launch(1'b0, 2'd1, MAJ3_TT, MAJ3_TT, 8'd64, 1'b1, 1'b1);
        wait_idle("t6a_fresh");

        // Asynchronous reset at m=90.
        launch(1'b0, 2'd2, NET7_TT, '0, 8'd0, 1'b0, 1'b0);
        wait_x("t6r", 7'd90);
        rst_n = 1'b0;
        #1;
        check("t6r_busy", busy0, 0);
        check("t6r_x", x0, 0);
        check("t6r_valid", v0, 0);
        check("t6r_tt", tt0, 0);
        check("t6r_ones", ones0, 0);
        check("t6r_match", m0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("t6r_still_idle", cur_v, 0);
        launch(1'b0, 2'd2, NET7_TT, NET7_TT, 8'd64, 1'b1, 1'b1);
        wait_idle("t6r_fresh");

        repeat (3) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
